// File: rtl/sprite_draw_engine_pkg.sv
// Shared constants, encodings and address helper for the sprite draw engine.
package sprite_draw_engine_pkg;

  localparam int unsigned SCREEN_W  = 320;
  localparam int unsigned SCREEN_H  = 240;
  localparam int unsigned COLOUR_W  = 9;
  localparam int unsigned BG_ADDR_W = 17;
  localparam int unsigned COORD_W   = 10;

  typedef enum logic {
    KIND_BG   = 1'b0,
    KIND_CHAR = 1'b1
  } kind_e;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StDrain,
    StDone,
    StRelease
  } state_e;

  // y*320 + x as shift-and-add; modulo 2^17 arithmetic gives the truncated address directly.
  function automatic logic [BG_ADDR_W-1:0] bg_addr_of(input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] y);
    logic [BG_ADDR_W-1:0] w_x;
    logic [BG_ADDR_W-1:0] w_y;
    w_x = BG_ADDR_W'(x);
    w_y = BG_ADDR_W'(y);
    return (w_y << 8) + (w_y << 6) + w_x;
  endfunction

endpackage

// File: rtl/sprite_draw_engine_char_rom.sv
// Character sprite ROM, Depth x ColourW, synchronous read with one cycle of latency.
// Every seventh word holds the transparent key colour; the rest form a fixed gradient.
module char_sprite_rom #(
  parameter int unsigned       Depth     = 64,
  parameter int unsigned       AddrW     = 6,
  parameter int unsigned       ColourW   = 9,
  parameter logic [ColourW-1:0] KeyColour = 9'h1FF
) (
  input  logic               i_clk,
  input  logic [AddrW-1:0]   i_addr,
  output logic [ColourW-1:0] o_data
);

  logic [ColourW-1:0] w_rom [Depth];
  logic [ColourW-1:0] r_data;

  for (genvar i = 0; i < Depth; i++) begin : g_rom
    assign w_rom[i] = (i % 7 == 0) ? KeyColour : ColourW'(i * 5);
  end

  always_ff @(posedge i_clk) begin
    r_data <= w_rom[i_addr];
  end

  assign o_data = r_data;

endmodule

// File: rtl/sprite_draw_engine.sv
// Scans a SPRITE_W x SPRITE_H box and emits one VGA write per pixel, background or character.
// Optional SPRITE_TRANSPARENCY_EN: character pixels equal to KEY_COLOUR are not plotted.
module sprite_draw_engine #(
  parameter int unsigned        SPRITE_W   = 8,
  parameter int unsigned        SPRITE_H   = 8,
  parameter int unsigned        COLOUR_W   = sprite_draw_engine_pkg::COLOUR_W,
  parameter logic [COLOUR_W-1:0] KEY_COLOUR = 9'h1FF
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        drawBG,
  input  logic                                        drawChar,
  input  logic [8:0]                                  xCoordinate,
  input  logic [7:0]                                  yCoordinate,
  output logic [sprite_draw_engine_pkg::BG_ADDR_W-1:0] bg_addr,
  input  logic [COLOUR_W-1:0]                         bg_data,
  output logic [8:0]                                  vga_x,
  output logic [7:0]                                  vga_y,
  output logic [COLOUR_W-1:0]                         colour,
  output logic                                        plot,
  output logic                                        doneBG,
  output logic                                        doneChar
);
  import sprite_draw_engine_pkg::*;

  localparam int unsigned        NPix   = SPRITE_W * SPRITE_H;
  localparam int unsigned        CxW    = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int unsigned        CyW    = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int unsigned        RomAw  = CxW + CyW;
  localparam logic [CxW-1:0]     CxLast = CxW'(SPRITE_W - 1);
  localparam logic [CyW-1:0]     CyLast = CyW'(SPRITE_H - 1);
  localparam logic [COORD_W-1:0] XLimit = COORD_W'(SCREEN_W);
  localparam logic [COORD_W-1:0] YLimit = COORD_W'(SCREEN_H);

  state_e               r_state;
  state_e               w_state_d;
  kind_e                r_kind;
  logic [8:0]           r_x0;
  logic [7:0]           r_y0;
  logic [CxW-1:0]       r_cx;
  logic [CyW-1:0]       r_cy;
  logic                 r_drain;

  logic                 r_s1_valid;
  logic                 r_s1_clip;
  logic [8:0]           r_s1_x;
  logic [7:0]           r_s1_y;

  logic                 r_plot;
  logic [8:0]           r_vga_x;
  logic [7:0]           r_vga_y;
  logic [COLOUR_W-1:0]  r_colour;

  logic [COORD_W-1:0]   w_px;
  logic [COORD_W-1:0]   w_py;
  logic                 w_clip;
  logic                 w_last;
  logic                 w_req_any;
  logic                 w_req_held;
  logic                 w_key;
  logic [RomAw-1:0]     w_rom_addr;
  logic [COLOUR_W-1:0]  w_rom_data;
  logic [COLOUR_W-1:0]  w_src;

  // Screen coordinates carry an extra bit so boxes near the right/bottom edge clip, not wrap.
  always_comb begin
    w_px       = COORD_W'(r_x0) + COORD_W'(r_cx);
    w_py       = COORD_W'(r_y0) + COORD_W'(r_cy);
    w_clip     = (w_px >= XLimit) || (w_py >= YLimit);
    w_last     = (r_cx == CxLast) && (r_cy == CyLast);
    w_rom_addr = {r_cy, r_cx};
    w_req_any  = drawBG || drawChar;
    w_req_held = (r_kind == KIND_BG) ? drawBG : drawChar;
    w_src      = (r_kind == KIND_CHAR) ? w_rom_data : bg_data;
  end

  assign bg_addr = bg_addr_of(w_px, w_py);

`ifdef SPRITE_TRANSPARENCY_EN
  assign w_key = (r_kind == KIND_CHAR) && (w_rom_data == KEY_COLOUR);
`else
  assign w_key = 1'b0;
`endif

  char_sprite_rom #(
    .Depth    (NPix),
    .AddrW    (RomAw),
    .ColourW  (COLOUR_W),
    .KeyColour(KEY_COLOUR)
  ) u_char_rom (
    .i_clk (clock),
    .i_addr(w_rom_addr),
    .o_data(w_rom_data)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:    if (w_req_any) w_state_d = StScan;
      StScan:    if (w_last) w_state_d = StDrain;
      StDrain:   if (r_drain) w_state_d = StDone;
      StDone:    w_state_d = StRelease;
      StRelease: if (!w_req_held) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_kind  <= KIND_BG;
      r_x0    <= '0;
      r_y0    <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_state_d;
      case (r_state)
        StIdle: begin
          if (w_req_any) begin
            r_x0    <= xCoordinate;
            r_y0    <= yCoordinate;
            r_kind  <= drawBG ? KIND_BG : KIND_CHAR;
            r_cx    <= '0;
            r_cy    <= '0;
            r_drain <= 1'b0;
          end
        end
        StScan: begin
          if (r_cx == CxLast) begin
            r_cx <= '0;
            r_cy <= (r_cy == CyLast) ? '0 : r_cy + 1'b1;
          end else begin
            r_cx <= r_cx + 1'b1;
          end
        end
        StDrain: r_drain <= ~r_drain;
        default: ;
      endcase
    end
  end

  // Stage 1 waits alongside the memory read; stage 2 registers the plot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_clip  <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_plot     <= 1'b0;
      r_vga_x    <= '0;
      r_vga_y    <= '0;
      r_colour   <= '0;
    end else begin
      r_s1_valid <= (r_state == StScan);
      r_s1_clip  <= w_clip;
      r_s1_x     <= w_px[8:0];
      r_s1_y     <= w_py[7:0];
      r_plot     <= r_s1_valid && !r_s1_clip && !w_key;
      r_vga_x    <= r_s1_x;
      r_vga_y    <= r_s1_y;
      r_colour   <= w_src;
    end
  end

  assign plot     = r_plot;
  assign vga_x    = r_vga_x;
  assign vga_y    = r_vga_y;
  assign colour   = r_colour;
  assign doneBG   = (r_state == StDone) && (r_kind == KIND_BG);
  assign doneChar = (r_state == StDone) && (r_kind == KIND_CHAR);

endmodule
